// File: rtl/axi4_bfm_pkg.sv
// Shared AXI4 types for the initiator BFM and the target models: burst and response encodings,
// channel field widths.
package axi4_bfm_pkg;

    localparam int unsigned AXI4_LEN_W  = 8;
    localparam int unsigned AXI4_SIZE_W = 3;

    typedef enum logic [1:0] {
        BurstFixed = 2'd0,
        BurstIncr  = 2'd1,
        BurstWrap  = 2'd2,
        BurstRsvd  = 2'd3
    } burst_t;

    typedef enum logic [1:0] {
        RespOkay   = 2'd0,
        RespExokay = 2'd1,
        RespSlverr = 2'd2,
        RespDecerr = 2'd3
    } resp_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [AXI4_LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address: FIXED holds, INCR steps by the beat size, WRAP steps and
// wraps inside the aligned (len+1)*size block.
module axi4_burst_addr_gen
    import axi4_bfm_pkg::*;
#(
    parameter int unsigned ADDRESS_BUS_WIDTH = 32
) (
    input  logic [ADDRESS_BUS_WIDTH-1:0] i_addr,
    input  logic [AXI4_SIZE_W-1:0]       i_size,
    input  logic [AXI4_LEN_W-1:0]        i_len,
    input  burst_t                       i_burst,
    output logic [ADDRESS_BUS_WIDTH-1:0] o_next_addr
);

    logic [ADDRESS_BUS_WIDTH-1:0] w_step;
    logic [ADDRESS_BUS_WIDTH-1:0] w_incr;
    logic [ADDRESS_BUS_WIDTH-1:0] w_wrap_mask;

    always_comb begin
        w_step      = ADDRESS_BUS_WIDTH'(1) << i_size;
        w_incr      = i_addr + w_step;
        w_wrap_mask = ((ADDRESS_BUS_WIDTH'(i_len) + ADDRESS_BUS_WIDTH'(1)) << i_size)
                      - ADDRESS_BUS_WIDTH'(1);
        unique case (i_burst)
            BurstIncr: o_next_addr = w_incr;
            BurstWrap: o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            BurstFixed, BurstRsvd: o_next_addr = i_addr;
            default:   o_next_addr = i_addr;
        endcase
    end

endmodule

// File: rtl/axi4_targ_wr_mem.sv
// AXI4 write-path target backed by a byte-enabled memory, one burst at a time, with a backdoor
// read port. Define AXI4_TARG_WR_BACKPRESSURE_EN for LFSR-driven AWREADY/WREADY throttling.
module axi4_targ_wr_mem
    import axi4_bfm_pkg::*;
#(
    parameter int unsigned DATA_BUS_WIDTH    = 32,
    parameter int unsigned ADDRESS_BUS_WIDTH = 32,
    parameter int unsigned ID_BUS_WIDTH      = 4,
    parameter int unsigned MEM_DEPTH_WORDS   = 1024
) (
    input  logic                               ACLK,
    input  logic                               ARESETn,
    input  logic [ID_BUS_WIDTH-1:0]            AWID,
    input  logic [ADDRESS_BUS_WIDTH-1:0]       AWADDR,
    input  logic [AXI4_LEN_W-1:0]              AWLEN,
    input  logic [AXI4_SIZE_W-1:0]             AWSIZE,
    input  logic [1:0]                         AWBURST,
    input  logic                               AWVALID,
    output logic                               AWREADY,
    input  logic [DATA_BUS_WIDTH-1:0]          WDATA,
    input  logic [DATA_BUS_WIDTH/8-1:0]        WSTRB,
    input  logic                               WLAST,
    input  logic                               WVALID,
    output logic                               WREADY,
    output logic [ID_BUS_WIDTH-1:0]            BID,
    output logic [1:0]                         BRESP,
    output logic                               BVALID,
    input  logic                               BREADY,
    input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] DBG_ADDR,
    output logic [DATA_BUS_WIDTH-1:0]          DBG_RDATA
);

    localparam int unsigned BYTE_LANES = DATA_BUS_WIDTH / 8;
    localparam int unsigned LANE_W     = $clog2(BYTE_LANES);
    localparam int unsigned IDX_W      = $clog2(MEM_DEPTH_WORDS);
    localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH_WORDS) * longint'(BYTE_LANES);
    localparam logic [AXI4_SIZE_W-1:0] MAX_SIZE = AXI4_SIZE_W'(LANE_W);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StResp
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [ID_BUS_WIDTH-1:0]        r_id;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_addr;
    logic [AXI4_LEN_W-1:0]          r_len;
    logic [AXI4_SIZE_W-1:0]         r_size;
    burst_t                         r_burst;
    logic [AXI4_LEN_W-1:0]          r_cnt;
    resp_t                          r_resp;
    logic                           r_wr_en;
    logic [DATA_BUS_WIDTH-1:0]      r_mem [MEM_DEPTH_WORDS];

    logic                           w_aw_gate;
    logic                           w_w_gate;
    logic                           w_aw_hs;
    logic                           w_w_hs;
    logic                           w_last_beat;
    logic                           w_wlast_err;
    burst_t                         w_aw_burst;
    logic                           w_aw_slverr;
    logic                           w_aw_decerr;
    logic [ADDRESS_BUS_WIDTH-1:0]   w_next_addr;
    logic [IDX_W-1:0]               w_idx;

`ifdef AXI4_TARG_WR_BACKPRESSURE_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_aw_gate = r_lfsr[1];
    assign w_w_gate  = r_lfsr[0];
`else
    assign w_aw_gate = 1'b1;
    assign w_w_gate  = 1'b1;
`endif

    assign w_aw_burst  = burst_t'(AWBURST);
    assign w_aw_slverr = (w_aw_burst == BurstRsvd) || (AWSIZE > MAX_SIZE)
                         || ((w_aw_burst == BurstWrap) && !wrap_len_ok(AWLEN));
    assign w_aw_decerr = 64'(AWADDR) >= MEM_BYTES;

    assign w_aw_hs     = AWVALID && AWREADY;
    assign w_w_hs      = WVALID && WREADY;
    assign w_last_beat = (r_cnt == r_len);
    assign w_wlast_err = (WLAST != w_last_beat);
    assign w_idx       = IDX_W'(r_addr >> LANE_W);

    axi4_burst_addr_gen #(
        .ADDRESS_BUS_WIDTH(ADDRESS_BUS_WIDTH)
    ) u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        AWREADY     = 1'b0;
        WREADY      = 1'b0;
        BVALID      = 1'b0;
        unique case (r_state)
            StIdle: begin
                AWREADY = w_aw_gate;
                if (AWVALID && w_aw_gate) w_state_nxt = StData;
            end
            StData: begin
                WREADY = w_w_gate;
                if (WVALID && w_w_gate && w_last_beat) w_state_nxt = StResp;
            end
            StResp: begin
                BVALID = 1'b1;
                if (BREADY) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= BurstFixed;
            r_cnt   <= '0;
            r_resp  <= RespOkay;
            r_wr_en <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_id    <= AWID;
                r_addr  <= AWADDR;
                r_len   <= AWLEN;
                r_size  <= AWSIZE;
                r_burst <= w_aw_burst;
                r_cnt   <= '0;
                r_resp  <= w_aw_decerr ? RespDecerr : (w_aw_slverr ? RespSlverr : RespOkay);
                r_wr_en <= !(w_aw_decerr || w_aw_slverr);
            end
            if (w_w_hs) begin
                r_addr <= w_next_addr;
                r_cnt  <= r_cnt + 8'd1;
                // WLAST framing errors still write; DECERR outranks them.
                if (w_wlast_err && (r_resp != RespDecerr)) r_resp <= RespSlverr;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_w_hs && r_wr_en) begin
            for (int unsigned b = 0; b < BYTE_LANES; b++) begin
                if (WSTRB[b]) r_mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    assign BID       = r_id;
    assign BRESP     = r_resp;
    assign DBG_RDATA = r_mem[DBG_ADDR];

endmodule

// File: tb/tb_axi4_targ_wr_mem.sv
// Randomized self-checking bench for axi4_targ_wr_mem against a byte-level reference memory
// and an AXI4 burst address model.
module tb_axi4_targ_wr_mem;

    localparam int unsigned DEPTH     = 1024;
    localparam int unsigned MEM_BYTES = 4096;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [9:0]  DBG_ADDR = '0;
    logic [31:0] DBG_RDATA;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem  [DEPTH];
    logic [31:0] m_mask [DEPTH];
    logic [31:0] g_data [256];
    logic [3:0]  g_strb [256];

    axi4_targ_wr_mem u_dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWBURST   (AWBURST),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .DBG_ADDR  (DBG_ADDR),
        .DBG_RDATA (DBG_RDATA)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte address of beat i, straight from the AXI4 burst definitions.
    function automatic int unsigned beat_addr(int unsigned start, int unsigned len,
                                              int unsigned size, int unsigned burst,
                                              int unsigned i);
        int unsigned s = 1 << size;
        int unsigned blk, lower;
        case (burst)
            1: return start + i * s;
            2: begin
                blk   = (len + 1) * s;
                lower = start - (start % blk);
                return lower + ((start - lower + i * s) % blk);
            end
            default: return start;
        endcase
    endfunction

    function automatic void model_write(int unsigned idx, logic [31:0] d, logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                m_mem[idx][b*8 +: 8]  = d[b*8 +: 8];
                m_mask[idx][b*8 +: 8] = 8'hFF;
            end
        end
    endfunction

    task automatic dbg_rd(input int unsigned idx, output logic [31:0] d);
        DBG_ADDR = 10'(idx);
        #1;
        d = DBG_RDATA;
    endtask

    task automatic dbg_chk(input string tag, input int unsigned idx);
        logic [31:0] d;
        if (m_mask[idx] != 32'h0) begin
            dbg_rd(idx, d);
            chk_eq(tag, {32'h0, d & m_mask[idx]}, {32'h0, m_mem[idx] & m_mask[idx]});
        end
    endtask

    // Entered just after a rising edge; leaves just after the edge that took the handshake.
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit ok);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!AWREADY && n < 100);
        ok = AWREADY;
        if (!ok) chk_eq("aw_timeout", {63'h0, AWREADY}, 64'h1);
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last,
                          output bit ok);
        int n = 0;
        WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!WREADY && n < 100);
        ok = WREADY;
        if (!ok) chk_eq("w_timeout", {63'h0, WREADY}, 64'h1);
        @(posedge ACLK);
        #1;
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic run_burst(input logic [3:0] id, input int unsigned addr,
                             input int unsigned len, input int unsigned size,
                             input int unsigned burst, input int bad_last,
                             input int unsigned bready_dly);
        bit ok;
        bit dec, slv, wr_ok;
        int n;
        logic [1:0] exp_resp;
        int unsigned idx;
        int unsigned touched[$];

        @(posedge ACLK);
        #1;
        dec   = addr >= MEM_BYTES;
        wr_ok = !(burst == 3 || size > 2 || (burst == 2 && !(len inside {1, 3, 7, 15})));
        slv   = !wr_ok || bad_last >= 0;
        exp_resp = dec ? 2'd3 : (slv ? 2'd2 : 2'd0);
        wr_ok = wr_ok && !dec;

        aw_send(id, addr, 8'(len), 3'(size), 2'(burst), ok);
        if (!ok) return;
        for (int unsigned i = 0; i <= len; i++) begin
            w_beat(g_data[i], g_strb[i], (i == len) ^ (int'(i) == bad_last), ok);
            if (!ok) return;
            if (wr_ok) begin
                idx = (beat_addr(addr, len, size, burst, i) / 4) % DEPTH;
                model_write(idx, g_data[i], g_strb[i]);
                touched.push_back(idx);
            end
        end
        chk_eq("bvalid_latency", {63'h0, BVALID}, 64'h1);
        n = 0;
        while (!BVALID && n < 50) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        chk_eq("bid", {60'h0, BID}, {60'h0, id});
        chk_eq("bresp", {62'h0, BRESP}, {62'h0, exp_resp});
        for (int unsigned k = 0; k < bready_dly; k++) begin
            @(posedge ACLK);
            #1;
            chk_eq("hold_bvalid", {63'h0, BVALID}, 64'h1);
            chk_eq("hold_bid", {60'h0, BID}, {60'h0, id});
            chk_eq("hold_bresp", {62'h0, BRESP}, {62'h0, exp_resp});
`ifndef AXI4_TARG_WR_BACKPRESSURE_EN
            chk_eq("hold_awready", {63'h0, AWREADY}, 64'h0);
`endif
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK);
        #1;
        BREADY = 1'b0;
        chk_eq("bvalid_drop", {63'h0, BVALID}, 64'h0);
`ifndef AXI4_TARG_WR_BACKPRESSURE_EN
        chk_eq("awready_after_b", {63'h0, AWREADY}, 64'h1);
`endif
        foreach (touched[j]) dbg_chk("mem_burst", touched[j]);
    endtask

    task automatic chk_word(input string tag, input int unsigned idx, input logic [31:0] exp);
        logic [31:0] d;
        dbg_rd(idx, d);
        chk_eq(tag, {32'h0, d}, {32'h0, exp});
    endtask

    task automatic fill_rand(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            g_data[i] = $urandom;
            g_strb[i] = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        bit ok;
        int unsigned r_burst, r_size, r_len, r_addr;
        int r_bad;

        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_mask[i] = '0;
        end

        // Reset values
        #12;
        chk_eq("rst_awready", {63'h0, AWREADY}, 64'h1);
        chk_eq("rst_wready", {63'h0, WREADY}, 64'h0);
        chk_eq("rst_bvalid", {63'h0, BVALID}, 64'h0);
        chk_eq("rst_bid", {60'h0, BID}, 64'h0);
        chk_eq("rst_bresp", {62'h0, BRESP}, 64'h0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // INCR, 4 full words
        g_data[0] = 32'h11; g_data[1] = 32'h22; g_data[2] = 32'h33; g_data[3] = 32'h44;
        for (int i = 0; i < 4; i++) g_strb[i] = 4'hF;
        run_burst(4'd5, 32'h100, 3, 2, 1, -1, 0);
        chk_word("incr_w0", 'h40, 32'h11);
        chk_word("incr_w1", 'h41, 32'h22);
        chk_word("incr_w2", 'h42, 32'h33);
        chk_word("incr_w3", 'h43, 32'h44);

        // WRAP from 0x38 wraps to 0x30
        g_data[0] = 32'h1; g_data[1] = 32'h2; g_data[2] = 32'h3; g_data[3] = 32'h4;
        run_burst(4'd2, 32'h38, 3, 2, 2, -1, 0);
        chk_word("wrap_e", 'hE, 32'h1);
        chk_word("wrap_f", 'hF, 32'h2);
        chk_word("wrap_c", 'hC, 32'h3);
        chk_word("wrap_d", 'hD, 32'h4);

        // FIXED, merged strobes
        g_data[0] = 32'hAAAA_BBBB; g_strb[0] = 4'h3;
        g_data[1] = 32'hCCCC_DDDD; g_strb[1] = 4'hC;
        run_burst(4'd9, 32'h20, 1, 2, 0, -1, 0);
        chk_word("fixed_merge", 8, 32'hCCCC_BBBB);

        // Early WLAST, reserved burst, decode error
        fill_rand(4);
        run_burst(4'd3, 32'h300, 3, 2, 1, 1, 0);
        fill_rand(4);
        run_burst(4'd4, 32'h100, 3, 2, 3, -1, 0);
        chk_word("rsvd_untouched0", 'h40, 32'h11);
        chk_word("rsvd_untouched3", 'h43, 32'h44);
        g_data[0] = 32'h1234_5678; g_strb[0] = 4'hF;
        run_burst(4'd1, 32'h0, 0, 2, 1, -1, 0);
        g_data[0] = 32'hDEAD_BEEF;
        run_burst(4'd7, 32'h1000, 0, 2, 1, -1, 0);
        chk_word("decerr_untouched", 0, 32'h1234_5678);

        // Long BREADY stall
        fill_rand(2);
        run_burst(4'hA, 32'h400, 1, 2, 1, -1, 10);

        // Reset mid-burst after two beats
        @(posedge ACLK);
        #1;
        fill_rand(4);
        g_strb[0] = 4'hF; g_strb[1] = 4'hF;
        aw_send(4'd6, 32'h200, 8'd3, 3'd2, 2'd1, ok);
        w_beat(g_data[0], 4'hF, 1'b0, ok);
        model_write('h80, g_data[0], 4'hF);
        w_beat(g_data[1], 4'hF, 1'b0, ok);
        model_write('h81, g_data[1], 4'hF);
        #2;
        ARESETn = 1'b0;
        #1;
        chk_eq("mid_rst_awready", {63'h0, AWREADY}, 64'h1);
        chk_eq("mid_rst_wready", {63'h0, WREADY}, 64'h0);
        chk_eq("mid_rst_bvalid", {63'h0, BVALID}, 64'h0);
        chk_eq("mid_rst_bid", {60'h0, BID}, 64'h0);
        chk_eq("mid_rst_bresp", {62'h0, BRESP}, 64'h0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK);
            #1;
            chk_eq("post_rst_no_b", {63'h0, BVALID}, 64'h0);
        end
        chk_word("rst_kept0", 'h80, g_data[0]);
        chk_word("rst_kept1", 'h81, g_data[1]);
        fill_rand(4);
        run_burst(4'd6, 32'h200, 3, 2, 1, -1, 1);

        // Randomized bursts
        for (int t = 0; t < 60; t++) begin
            r_burst = $urandom_range(0, 9);
            r_burst = (r_burst == 0) ? 3 : (r_burst <= 3 ? 0 : (r_burst <= 6 ? 1 : 2));
            r_size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            if (r_burst == 2 && $urandom_range(0, 7) != 0) begin
                case ($urandom_range(0, 3))
                    0: r_len = 1;
                    1: r_len = 3;
                    2: r_len = 7;
                    default: r_len = 15;
                endcase
            end else begin
                r_len = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 40)
                                                    : $urandom_range(0, 15);
            end
            if ($urandom_range(0, 7) == 0) r_addr = MEM_BYTES + $urandom_range(0, 4095);
            else r_addr = $urandom_range(0, 4095) & ~((1 << r_size) - 1);
            r_bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, r_len)) : -1;
            fill_rand(r_len + 1);
            run_burst(4'($urandom_range(0, 15)), r_addr, r_len, r_size, r_burst, r_bad,
                      $urandom_range(0, 3));
        end

        for (int unsigned i = 0; i < DEPTH; i++) dbg_chk("mem_sweep", i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
